imm_gen_pipe: RTL and testbench

Parametrised, pipelined RV32I/RV64I immediate generator between instruction fetch/decode and the execute stage. Decodes all base immediate formats (I, S, B, U, J), including JALR, LUI, AUIPC, JAL and shift-immediate shamt handling. Presents a one-cycle registered result through a valid/ready handshake with flush support. Flags unrecognised opcodes and counts them in a saturating counter.

---
 rtl/imm_gen_pipe.sv | 138 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with a one-deep registered output stage,
// valid/ready handshake, flush, and a saturating illegal-opcode counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_data,
  output logic [2:0]       imm_fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  fmt_e              dec_fmt;
  logic              dec_illegal;
  logic              shamt_sel;
  logic signed [31:0] raw_imm;
  logic [XLEN-1:0]   dec_imm;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   imm_data_q, imm_data_d;
  fmt_e              imm_fmt_q, imm_fmt_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // All formats are assembled as a signed 32-bit value, then sign-extended to XLEN.
  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    shamt_sel   = 1'b0;
    raw_imm     = '0;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        raw_imm = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0010011: begin
        dec_fmt   = FMT_I;
        raw_imm   = {{20{instr[31]}}, instr[31:20]};
        shamt_sel = (funct3 == 3'b001) || (funct3 == 3'b101);
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        raw_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        raw_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        raw_imm = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        raw_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: dec_illegal = 1'b1;
    endcase

    dec_imm = XLEN'(raw_imm);
    if (shamt_sel) begin
      dec_imm                = '0;
      dec_imm[SHAMT_W-1:0]   = instr[20 +: SHAMT_W];
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d   = out_valid_q;
    imm_data_d    = imm_data_q;
    imm_fmt_d     = imm_fmt_q;
    illegal_d     = illegal_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      imm_data_d  = dec_imm;
      imm_fmt_d   = dec_fmt;
      illegal_d   = dec_illegal;
      if (dec_illegal && (illegal_cnt_q != '1)) begin
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      imm_data_q    <= '0;
      imm_fmt_q     <= FMT_NONE;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      imm_data_q    <= imm_data_d;
      imm_fmt_q     <= imm_fmt_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign imm_data    = imm_data_q;
  assign imm_fmt     = imm_fmt_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Table-driven bench for imm_gen_pipe: three instances (RV32, RV64, 2-bit
// counter) share the inputs; a queue scoreboard tracks pending results.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  logic        in_ready_s, out_valid_s, ill_s;
  logic [31:0] imm_s;
  logic [2:0]  fmt_s;
  logic [1:0]  cnt_s;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .flush(flush), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_data(imm32), .imm_fmt(fmt32), .illegal(ill32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_data(imm64), .imm_fmt(fmt64), .illegal(ill64), .illegal_cnt(cnt64)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .instr(instr), .flush(flush), .out_valid(out_valid_s), .out_ready(out_ready),
    .imm_data(imm_s), .imm_fmt(fmt_s), .illegal(ill_s), .illegal_cnt(cnt_s)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  vec_t sb[$];
  vec_t hold;
  vec_t idle_v;
  bit   hold_known;
  int   m_cnt16;
  int   m_cnt2;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit   v;
    vec_t e;
    v = (sb.size() != 0);
    chk("out_valid32", out_valid32, v);
    chk("out_valid64", out_valid64, v);
    chk("out_valid_sat", out_valid_s, v);
    e = v ? sb[0] : hold;
    if (v || hold_known) begin
      chk("imm32", imm32, e.e32);
      chk("imm64", imm64, e.e64);
      chk("imm_sat", imm_s, e.e32);
      chk("fmt32", fmt32, e.fmt);
      chk("fmt64", fmt64, e.fmt);
      chk("illegal32", ill32, e.ill);
      chk("illegal64", ill64, e.ill);
    end
    chk("illegal_cnt32", cnt32, m_cnt16);
    chk("illegal_cnt64", cnt64, m_cnt16);
    chk("illegal_cnt_sat", cnt_s, m_cnt2);
  endtask

  // Inputs are already driven; v is the expectation for the presented instr.
  task automatic tick(input vec_t v);
    bit exp_rdy;
    bit acc;
    #1;
    exp_rdy = (sb.size() == 0) || out_ready;
    chk("in_ready32", in_ready32, exp_rdy);
    chk("in_ready64", in_ready64, exp_rdy);
    acc = in_valid && exp_rdy && !flush;
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      hold       = idle_v;
      hold_known = 1'b1;
      m_cnt16    = 0;
      m_cnt2     = 0;
    end else if (flush) begin
      sb.delete();
      hold_known = 1'b0;
    end else begin
      if (sb.size() != 0 && out_ready) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(v);
        hold       = v;
        hold_known = 1'b1;
        if (v.ill) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input vec_t v, input bit vld, input bit rdy, input bit fl);
    instr     = v.instr;
    in_valid  = vld;
    out_ready = rdy;
    flush     = fl;
    tick(v);
  endtask

  vec_t ill_v;

  initial begin
    idle_v = '{32'h0000_0013, 32'h0, 64'h0, 3'd0, 1'b0};
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0}; // addi -1
    vecs[1]  = '{32'h00112623, 32'h0000000C, 64'h00000000_0000000C, 3'd2, 1'b0}; // sw
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0}; // beq -4
    vecs[3]  = '{32'h123450B7, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0}; // lui
    vecs[4]  = '{32'h001000EF, 32'h00000800, 64'h00000000_00000800, 3'd5, 1'b0}; // jal +2048
    vecs[5]  = '{32'h43F0D093, 32'h0000001F, 64'h00000000_0000003F, 3'd1, 1'b0}; // srai 63
    vecs[6]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0}; // lui neg
    vecs[7]  = '{32'h0000007F, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1}; // illegal
    vecs[8]  = '{32'h00209093, 32'h00000002, 64'h00000000_00000002, 3'd1, 1'b0}; // slli 2
    vecs[9]  = '{32'hFFC0A083, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0}; // lw -4
    vecs[10] = '{32'hFFC08067, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0}; // jalr -4
    vecs[11] = '{32'hFFFFF017, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000, 3'd4, 1'b0}; // auipc
    vecs[12] = '{32'h00000033, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1}; // R-type
    vecs[13] = '{32'h02009093, 32'h00000000, 64'h00000000_00000020, 3'd1, 1'b0}; // slli 32
    ill_v = vecs[7];

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    hold = idle_v; hold_known = 1'b1; m_cnt16 = 0; m_cnt2 = 0;
    check_outputs();
    rst_n = 1'b1;

    // Back-to-back stream through the whole table.
    for (int i = 0; i < NV; i++) drive(vecs[i], 1'b1, 1'b1, 1'b0);
    drive(idle_v, 1'b0, 1'b1, 1'b0);
    drive(idle_v, 1'b0, 1'b1, 1'b0);

    // Stall: beq held while lui waits at the input.
    drive(vecs[2], 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(vecs[3], 1'b1, 1'b0, 1'b0);
      chk("stall_in_ready", in_ready32, 1'b0);
      chk("stall_imm", imm32, 32'hFFFFFFFC);
    end
    drive(vecs[3], 1'b1, 1'b1, 1'b0);
    chk("after_stall_imm", imm32, 32'h12345000);
    drive(idle_v, 1'b0, 1'b1, 1'b0);

    // Illegal accepts drive the 2-bit counter into saturation.
    for (int i = 0; i < 5; i++) drive(ill_v, 1'b1, 1'b1, 1'b0);
    chk("sat_cnt", cnt_s, 2'd3);
    drive(idle_v, 1'b0, 1'b1, 1'b0);

    // Flush with a held result and an illegal instr at the input.
    drive(vecs[0], 1'b1, 1'b1, 1'b0);
    drive(ill_v, 1'b1, 1'b0, 1'b1);
    chk("flush_valid", out_valid32, 1'b0);
    drive(ill_v, 1'b1, 1'b1, 1'b1);
    drive(idle_v, 1'b0, 1'b1, 1'b0);

    // Reset while stalled.
    drive(vecs[6], 1'b1, 1'b0, 1'b0);
    drive(vecs[1], 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(vecs[1], 1'b1, 1'b0, 1'b0);
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_cnt", cnt32, 16'h0);
    rst_n = 1'b1;
    drive(idle_v, 1'b0, 1'b1, 1'b0);

    // Random handshake traffic over the table.
    for (int c = 0; c < 300; c++) begin
      drive(vecs[$urandom_range(0, NV-1)], 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    drive(idle_v, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
